// File: rtl/rd53_weight_enum.sv
// rd53_weight_enum: streams every 5-bit pattern of Hamming weight k,
// one per cycle, in strict numeric order (ascending or descending).
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req_valid/req_ready     weight request handshake, req_weight = k
//   out_valid/out_ready     pattern beat handshake
//   out_pattern             bit i drives rd53 input x_i
//   out_index               beat number within the stream
//   out_last                final beat of the stream
//   out_err                 single error beat for k > 5
module rd53_weight_enum #(
   parameter bit DESCEND = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_weight,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [4:0] out_pattern,
   output logic [3:0] out_index,
   output logic       out_last,
   output logic       out_err
);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t     state_q;
   state_t     state_d;

   logic [2:0] weight_q;
   logic [4:0] pattern_q;
   logic [3:0] index_q;
   logic       err_q;

   logic       accept;
   logic       advance;
   logic       last_beat;
   logic [3:0] last_index;
   logic [4:0] first_pat;
   logic [4:0] next_pat;

   int         pos;
   int         ones;
   logic       found;

   // Stream length minus one, C(5,k)-1.
   always_comb begin
      last_index = 4'd0;
      unique case (weight_q)
         3'd0, 3'd5: last_index = 4'd0;
         3'd1, 3'd4: last_index = 4'd4;
         3'd2, 3'd3: last_index = 4'd9;
         default:    last_index = 4'd0;
      endcase
   end

   // Error streams are exactly one beat long.
   assign last_beat = err_q | (index_q == last_index);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      out_valid = 1'b0;
      accept    = 1'b0;
      advance   = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            accept    = req_valid;
            if (req_valid) begin
               state_d = EMIT;
            end
         end
         EMIT: begin
            out_valid = 1'b1;
            advance   = out_ready;
            if (out_ready && last_beat) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // First pattern: k ones packed at the low end (ascending)
   // or at the high end (descending).
   always_comb begin
      first_pat = '0;
      for (int i = 0; i < 5; i++) begin
         if (DESCEND) begin
            first_pat[i] = (i >= 5 - int'(req_weight));
         end else begin
            first_pat[i] = (i < int'(req_weight));
         end
      end
      if (req_weight > 3'd5) begin
         first_pat = '0;
      end
   end

   // Next value with equal popcount.
   // Ascending: lowest "01" pair (bit p set, p+1 clear) moves its
   // one up to p+1; the ones below p collapse to the bottom.
   // Descending: lowest "10" pair (bit p clear, p+1 set) moves the
   // one down to p; the ones below p pack directly beneath it.
   always_comb begin
      pos      = 0;
      ones     = 0;
      found    = 1'b0;
      next_pat = '0;
      for (int i = 0; i < 4; i++) begin
         if (!found) begin
            if (DESCEND ? (!pattern_q[i] && pattern_q[i+1])
                        : (pattern_q[i] && !pattern_q[i+1])) begin
               found = 1'b1;
               pos   = i;
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         if (i < pos && pattern_q[i]) begin
            ones = ones + 1;
         end
      end
      for (int i = 0; i < 5; i++) begin
         if (i > pos + 1) begin
            next_pat[i] = pattern_q[i];
         end else if (i == pos + 1) begin
            next_pat[i] = !DESCEND;
         end else if (i == pos) begin
            next_pat[i] = DESCEND;
         end else if (DESCEND) begin
            next_pat[i] = (i >= pos - ones);
         end else begin
            next_pat[i] = (i < ones);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         weight_q  <= 3'd0;
         pattern_q <= 5'd0;
         index_q   <= 4'd0;
         err_q     <= 1'b0;
      end else if (accept) begin
         weight_q  <= req_weight;
         pattern_q <= first_pat;
         index_q   <= 4'd0;
         err_q     <= (req_weight > 3'd5);
      end else if (advance) begin
         if (last_beat) begin
            pattern_q <= 5'd0;
            index_q   <= 4'd0;
            err_q     <= 1'b0;
         end else begin
            pattern_q <= next_pat;
            index_q   <= index_q + 4'd1;
         end
      end
   end

   assign out_pattern = pattern_q;
   assign out_index   = index_q;
   assign out_last    = out_valid & last_beat;
   assign out_err     = out_valid & err_q;

endmodule

// File: doc/rd53_weight_enum.md
# rd53_weight_enum

Sequential inverse of the rd53 5-input weight counter. It accepts a requested Hamming weight k (0..5) and streams every 5-bit pattern whose ones-count equals k, one pattern per cycle, in strict numeric order. The stream uses a valid/ready handshake. It drives stimulus into, and cross-checks, the rd53 population-count logic within the same PLA design set.

## Interface

Parameters:
- DESCEND, default 0. Enumeration order: 0 = ascending numeric value, 1 = descending.

Ports:
- clk, input, 1. Single clock; all state updates on the rising edge.
- rst_n, input, 1. Asynchronous, active-low reset.
- req_valid, input, 1. Weight request present.
- req_ready, output, 1. Block accepts a request; equals (state == IDLE).
- req_weight, input, 3. Requested weight k.
- out_valid, output, 1. Pattern beat present.
- out_ready, input, 1. Downstream accepts the beat.
- out_pattern, output, 5. Pattern; bit i corresponds to input x_i.
- out_index, output, 4. Beat index within the stream, 0..C(5,k)-1.
- out_last, output, 1. Final beat of the stream.
- out_err, output, 1. Request was out of range (k > 5).

## Operation

- States:
  - IDLE: req_ready = 1 and out_valid = 0.
  - EMIT: req_ready = 0 and out_valid = 1.
- Transition IDLE -> EMIT on a request handshake (req_valid & req_ready). k is captured on that edge.
- First pattern:
  - DESCEND = 0: the low k bits set (k = 2 gives 00011).
  - DESCEND = 1: the high k bits set (k = 2 gives 11000).
  - k = 0 gives 00000 in either order.
- Next pattern on each output handshake (out_valid & out_ready) while not out_last:
  - DESCEND = 0: the smallest value greater than the current one with the same popcount.
  - DESCEND = 1: the largest value smaller than the current one with the same popcount.
  - The next-value function is combinational and produces no bubbles.
- out_index starts at 0 and increments by 1 per handshake. It never wraps within a stream.
- Stream lengths are C(5,k) = 1, 5, 10, 10, 5, 1 for k = 0..5.
- out_last is asserted when out_index == C(5,k)-1. This is equivalent to the pattern being 11111 >> (5-k) << (5-k) when ascending, or the low-k mask when descending.
- Handshake on the out_last beat returns the state to EMIT -> IDLE.
- Out-of-range k (6 or 7):
  - Exactly one beat is emitted: out_pattern = 00000, out_index = 0, out_last = 1, out_err = 1.
  - The state then returns to IDLE.
- out_err is 0 for every in-range beat.
- Invariant on every beat with out_err = 0: popcount(out_pattern) == k. The rd53 encoding {z0,z1,z2} of the pattern equals k.

## Timing

- Values held while rst_n = 0:
  - state IDLE and req_ready = 1.
  - out_valid = 0, out_pattern = 00000, out_index = 0, out_last = 0, out_err = 0.
- Request accepted at edge N: out_valid = 1 with the first pattern from edge N onward, visible in cycle N+1.
- Throughput: one pattern per cycle while out_ready = 1.
- Backpressure: while out_valid = 1 and out_ready = 0, out_pattern, out_index, out_last and out_err hold stable. out_valid must not drop.
- Last-beat handshake at edge M:
  - out_valid = 0 and req_ready = 1 in cycle M+1.
  - A new request may be accepted at edge M+1, giving a minimum one-cycle gap between streams.
- req_weight is ignored outside the accept edge. req_valid during EMIT is not accepted and must be held by the requester.
- rst_n asserted mid-stream:
  - All outputs take their reset values immediately (asynchronous).
  - The partial stream is abandoned; no out_last is emitted.
  - After deassertion the block is in IDLE.
- out_ready is ignored when out_valid = 0.

## Test plan

- DESCEND=0, k=2, out_ready tied 1 -> 10 consecutive beats: 00011, 00101, 00110, 01001, 01010, 01100, 10001, 10010, 10100, 11000. out_index runs 0..9; out_last is asserted only on 11000; req_ready returns 1 the next cycle.
- DESCEND=1, k=1 -> 10000, 01000, 00100, 00010, 00001, with out_last on 00001. Then k=0 -> a single beat 00000 with out_last = 1. Then k=5 -> a single beat 11111 with out_last = 1.
- k=6 -> a single beat with pattern 00000, index 0, out_last = 1, out_err = 1. A following k=3 stream has out_err = 0 on all 10 beats.
- k=3 with out_ready toggling pseudo-randomly:
  - All beats are held stable under stall.
  - The sequence matches the reference order with no duplicates or skips.
  - Every pattern's rd53 encoding is 011.
- Assert rst_n low after the 4th beat of a k=2 stream:
  - out_valid = 0 at once and req_ready = 1.
  - After release, a k=2 request restarts the stream at 00011 with index 0.
- req_valid held high during EMIT with req_weight changing -> that weight is not captured. The next stream starts only after out_last and uses the req_weight value present at that accept edge.
